// File: rtl/aes_gcm_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_gcm_seq_ctrl                                              |
// | Purpose  : AES-GCM phase controller. It sequences IDLE -> AAD -> payload |
// |            -> lengths -> tag around an external GHASH/CTR datapath,      |
// |            tracks stream byte counts against the programmed bit lengths, |
// |            builds the truncated tag and, in decrypt mode, checks it      |
// |            against a received tag.                                       |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            start/abort             - operation control                   |
// |            enc_mode, len_*_bits,   - operation setup, latched at start   |
// |            tag_len                                                       |
// |            aad_* / pld_*           - observed stream handshakes          |
// |            lens_done               - lengths block absorbed by GHASH     |
// |            tag_pre_xor*, tagmask*  - GHASH result and E(K,J0)            |
// |            tag_in, tag_in_we       - expected tag register write port    |
// |            phase, busy             - status                              |
// |            ghash_init, tagmask_start - datapath kick pulses              |
// |            tag_out*, auth_*        - results                             |
// |            len_err                 - length violation flag               |
// | Option   : `define AES_GCM_SEQ_CTRL_LEN_CHECK_EN enables length checking |
// |            (len_err, ERR phase). Without it len_err is tied low.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module aes_gcm_seq_ctrl #(
  parameter int BUS_BYTES = 16,
  parameter int LEN_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 enc_mode,
  input  logic [LEN_W-1:0]     len_aad_bits,
  input  logic [LEN_W-1:0]     len_pld_bits,
  input  logic [4:0]           tag_len,
  input  logic                 aad_valid,
  input  logic                 aad_ready,
  input  logic                 aad_last,
  input  logic [BUS_BYTES-1:0] aad_keep,
  input  logic                 pld_valid,
  input  logic                 pld_ready,
  input  logic                 pld_last,
  input  logic [BUS_BYTES-1:0] pld_keep,
  input  logic                 lens_done,
  input  logic [127:0]         tag_pre_xor,
  input  logic                 tag_pre_xor_valid,
  input  logic [127:0]         tagmask,
  input  logic                 tagmask_valid,
  input  logic [127:0]         tag_in,
  input  logic                 tag_in_we,
  output logic [2:0]           phase,
  output logic                 busy,
  output logic                 ghash_init,
  output logic                 tagmask_start,
  output logic [127:0]         tag_out,
  output logic                 tag_out_valid,
  output logic                 auth_done,
  output logic                 auth_fail,
  output logic                 len_err
);

  localparam int CNT_W = $clog2(BUS_BYTES) + 1;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_AAD  = 3'd1,
    PH_PLD  = 3'd2,
    PH_LENS = 3'd3,
    PH_TAG  = 3'd4,
    PH_DONE = 3'd5,
    PH_ERR  = 3'd6
  } phase_e;

  phase_e             state;
  logic               start_q;
  logic               mode_q;
  logic [4:0]         tag_len_q;
  logic [LEN_W-1:0]   rem_aad;
  logic [LEN_W-1:0]   rem_pld;
  logic [127:0]       tag_in_q;

  function automatic logic [CNT_W-1:0] popcnt(input logic [BUS_BYTES-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BUS_BYTES; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction

  function automatic logic [4:0] clamp_tag_len(input logic [4:0] tl);
    if (tl < 5'd4)       return 5'd4;
    else if (tl > 5'd16) return 5'd16;
    else                 return tl;
  endfunction

  // ---------------------------------------------------------------- status
  assign phase = state;
  assign busy  = (state == PH_AAD) || (state == PH_PLD) ||
                 (state == PH_LENS) || (state == PH_TAG);

  // Start is edge triggered; abort masks it so a cancel cycle never begins
  // a new operation.
  logic start_acc;
  assign start_acc = start & ~start_q & ~busy & ~abort;

  // ------------------------------------------------------ beat accounting
  logic             aad_beat, pld_beat;
  logic [CNT_W-1:0] aad_bytes, pld_bytes;
  logic [LEN_W-1:0] aad_dec, pld_dec;
  logic [LEN_W-1:0] aad_rem_nxt, pld_rem_nxt;
  logic             aad_cmp, pld_cmp;
  logic             aad_viol, pld_viol;

  assign aad_beat  = (state == PH_AAD) & aad_valid & aad_ready;
  assign pld_beat  = (state == PH_PLD) & pld_valid & pld_ready;
  assign aad_bytes = popcnt(aad_keep);
  assign pld_bytes = popcnt(pld_keep);
  assign aad_dec   = LEN_W'(aad_bytes) << 3;
  assign pld_dec   = LEN_W'(pld_bytes) << 3;

  // Remaining bit counts saturate at zero instead of wrapping on overrun.
  assign aad_rem_nxt = (rem_aad > aad_dec) ? (rem_aad - aad_dec) : '0;
  assign pld_rem_nxt = (rem_pld > pld_dec) ? (rem_pld - pld_dec) : '0;
  assign aad_cmp     = (aad_rem_nxt == '0) | aad_last;
  assign pld_cmp     = (pld_rem_nxt == '0) | pld_last;

`ifdef AES_GCM_SEQ_CTRL_LEN_CHECK_EN
  // Underrun (early last), overrun (beat larger than what remains) and any
  // beat after the stream has already drained are all length violations.
  assign aad_viol = aad_beat & ((rem_aad == '0) | (aad_dec > rem_aad) |
                                (aad_last & (rem_aad > aad_dec)));
  assign pld_viol = pld_beat & ((rem_pld == '0) | (pld_dec > rem_pld) |
                                (pld_last & (rem_pld > pld_dec)));

  logic len_err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_err_q <= 1'b0;
    end else if (abort || start_acc) begin
      len_err_q <= 1'b0;
    end else if (aad_viol || pld_viol) begin
      len_err_q <= 1'b1;
    end
  end
  assign len_err = len_err_q;
`else
  assign aad_viol = 1'b0;
  assign pld_viol = 1'b0;
  assign len_err  = 1'b0;
`endif

  // ------------------------------------------------------- tag generation
  logic [4:0]   drop_bytes;
  logic [127:0] keep_mask;
  logic [127:0] tag_full;
  logic         tag_mismatch;
  logic         tag_both_valid;

  // Truncation keeps the most-significant tag_len bytes, so the mask is an
  // all-ones word shifted left by the number of dropped bytes.
  assign drop_bytes     = 5'd16 - tag_len_q;
  assign keep_mask      = {128{1'b1}} << {drop_bytes, 3'b000};
  assign tag_full       = tag_pre_xor ^ tagmask;
  assign tag_mismatch   = |((tag_full ^ tag_in_q) & keep_mask);
  assign tag_both_valid = tag_pre_xor_valid & tagmask_valid;

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= PH_IDLE;
      start_q       <= 1'b0;
      mode_q        <= 1'b0;
      tag_len_q     <= '0;
      rem_aad       <= '0;
      rem_pld       <= '0;
      tag_in_q      <= '0;
      ghash_init    <= 1'b0;
      tagmask_start <= 1'b0;
      tag_out       <= '0;
      tag_out_valid <= 1'b0;
      auth_done     <= 1'b0;
      auth_fail     <= 1'b0;
    end else begin
      start_q       <= start;
      ghash_init    <= 1'b0;
      tagmask_start <= 1'b0;
      tag_out_valid <= 1'b0;
      auth_done     <= 1'b0;

      if (tag_in_we) tag_in_q <= tag_in;

      if (abort) begin
        state     <= PH_IDLE;
        rem_aad   <= '0;
        rem_pld   <= '0;
        auth_fail <= 1'b0;
      end else if (start_acc) begin
        mode_q     <= enc_mode;
        tag_len_q  <= clamp_tag_len(tag_len);
        rem_aad    <= len_aad_bits;
        rem_pld    <= len_pld_bits;
        auth_fail  <= 1'b0;
        tag_out    <= '0;
        ghash_init <= 1'b1;
        if (len_aad_bits != '0)      state <= PH_AAD;
        else if (len_pld_bits != '0) state <= PH_PLD;
        else                         state <= PH_LENS;
      end else begin
        case (state)
          PH_AAD: begin
            if (aad_beat) begin
              if (aad_viol) begin
                state <= PH_ERR;
              end else if (aad_cmp) begin
                rem_aad <= '0;
                state   <= (rem_pld != '0) ? PH_PLD : PH_LENS;
              end else begin
                rem_aad <= aad_rem_nxt;
              end
            end
          end
          PH_PLD: begin
            if (pld_beat) begin
              if (pld_viol) begin
                state <= PH_ERR;
              end else if (pld_cmp) begin
                rem_pld <= '0;
                state   <= PH_LENS;
              end else begin
                rem_pld <= pld_rem_nxt;
              end
            end
          end
          PH_LENS: begin
            if (lens_done) begin
              state         <= PH_TAG;
              tagmask_start <= 1'b1;
            end
          end
          PH_TAG: begin
            if (tag_both_valid) begin
              tag_out <= tag_full & keep_mask;
              if (mode_q) begin
                tag_out_valid <= 1'b1;
              end else begin
                auth_done <= 1'b1;
                auth_fail <= tag_mismatch;
              end
              state <= PH_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_gcm_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_gcm_seq_ctrl                                           |
// | Purpose  : Self-checking bench for aes_gcm_seq_ctrl: directed scenarios  |
// |            plus randomized operations checked against a byte-level model.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_aes_gcm_seq_ctrl;

  localparam int BB = 16;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, enc_mode;
  logic [LW-1:0] len_aad_bits, len_pld_bits;
  logic [4:0]    tag_len;
  logic          aad_valid, aad_ready, aad_last;
  logic [BB-1:0] aad_keep;
  logic          pld_valid, pld_ready, pld_last;
  logic [BB-1:0] pld_keep;
  logic          lens_done;
  logic [127:0]  tag_pre_xor, tagmask, tag_in;
  logic          tag_pre_xor_valid, tagmask_valid, tag_in_we;
  logic [2:0]    phase;
  logic          busy, ghash_init, tagmask_start, tag_out_valid;
  logic          auth_done, auth_fail, len_err;
  logic [127:0]  tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  aes_gcm_seq_ctrl #(.BUS_BYTES(BB), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .enc_mode(enc_mode),
    .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits), .tag_len(tag_len),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_last(aad_last), .aad_keep(aad_keep),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_last(pld_last), .pld_keep(pld_keep),
    .lens_done(lens_done), .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
    .tagmask(tagmask), .tagmask_valid(tagmask_valid), .tag_in(tag_in), .tag_in_we(tag_in_we),
    .phase(phase), .busy(busy), .ghash_init(ghash_init), .tagmask_start(tagmask_start),
    .tag_out(tag_out), .tag_out_valid(tag_out_valid), .auth_done(auth_done),
    .auth_fail(auth_fail), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ reference
  function automatic int model_tl(input int tl);
    if (tl < 4)  return 4;
    if (tl > 16) return 16;
    return tl;
  endfunction

  // Tag bytes are numbered from the MSB; only the first tl of them survive.
  function automatic logic [127:0] model_tag(input logic [127:0] pre, input logic [127:0] msk,
                                             input int tl);
    logic [127:0] f, r;
    f = pre ^ msk;
    r = '0;
    for (int b = 0; b < model_tl(tl); b++) r[127-8*b -: 8] = f[127-8*b -: 8];
    return r;
  endfunction

  function automatic int model_first(input int la, input int lp);
    if (la != 0) return 1;
    if (lp != 0) return 2;
    return 3;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; enc_mode = 0; len_aad_bits = '0; len_pld_bits = '0; tag_len = '0;
    aad_valid = 0; aad_ready = 0; aad_last = 0; aad_keep = '0;
    pld_valid = 0; pld_ready = 0; pld_last = 0; pld_keep = '0;
    lens_done = 0; tag_pre_xor = '0; tag_pre_xor_valid = 0; tagmask = '0; tagmask_valid = 0;
    tag_in = '0; tag_in_we = 0;
  endtask

  task automatic do_start(input logic enc, input int la, input int lp, input int tl);
    enc_mode = enc; len_aad_bits = LW'(la); len_pld_bits = LW'(lp); tag_len = 5'(tl);
    start = 1; tick(); start = 0;
  endtask

  task automatic write_tag_in(input logic [127:0] v);
    tag_in = v; tag_in_we = 1; tick(); tag_in_we = 0;
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) tick();
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_checks++; if ({busy, ghash_init, tagmask_start, tag_out_valid, auth_done, auth_fail, len_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0", {busy, ghash_init, tagmask_start, tag_out_valid, auth_done, auth_fail, len_err}); end
    n_checks++; if (tag_out !== 128'd0) begin n_fail++; $display("FAIL reset_tag_out: got %h want 0", tag_out); end
    rst_n = 1;
    tick();
    n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_release_phase: got %0d want 0", phase); end
  endtask

  task automatic test_encrypt_basic();
    do_start(1'b1, 160, 256, 16);
    n_checks++; if (phase !== 3'd1 || ghash_init !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL enc_accept: got phase %0d gi %b busy %b want 1 1 1", phase, ghash_init, busy); end
    aad_valid = 1; aad_ready = 1; aad_keep = 16'hFFFF; tick();
    n_checks++; if (phase !== 3'd1 || ghash_init !== 1'b0) begin
      n_fail++; $display("FAIL enc_aad_mid: got phase %0d gi %b want 1 0", phase, ghash_init); end
    aad_keep = 16'h000F; tick(); aad_valid = 0; aad_ready = 0;
    n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL enc_aad_done: got %0d want 2", phase); end
    pld_valid = 1; pld_ready = 1; pld_keep = 16'hFFFF; tick();
    n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL enc_pld_mid: got %0d want 2", phase); end
    tick(); pld_valid = 0; pld_ready = 0;
    n_checks++; if (phase !== 3'd3 || tagmask_start !== 1'b0) begin
      n_fail++; $display("FAIL enc_lens: got phase %0d tms %b want 3 0", phase, tagmask_start); end
    lens_done = 1; tick(); lens_done = 0;
    n_checks++; if (phase !== 3'd4 || tagmask_start !== 1'b1) begin
      n_fail++; $display("FAIL enc_tag_entry: got phase %0d tms %b want 4 1", phase, tagmask_start); end
    tick();
    n_checks++; if (phase !== 3'd4 || tagmask_start !== 1'b0 || tag_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL enc_tag_wait: got phase %0d tms %b tov %b want 4 0 0", phase, tagmask_start, tag_out_valid); end
    tag_pre_xor = {16{8'hA5}}; tagmask = {16{8'h0F}}; tag_pre_xor_valid = 1; tagmask_valid = 1;
    tick();
    n_checks++; if (tag_out !== {16{8'hAA}} || tag_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL enc_tag: got %h v%b want %h v1", tag_out, tag_out_valid, {16{8'hAA}}); end
    n_checks++; if (phase !== 3'd5 || busy !== 1'b0 || auth_done !== 1'b0) begin
      n_fail++; $display("FAIL enc_done: got phase %0d busy %b ad %b want 5 0 0", phase, busy, auth_done); end
    tick();
    n_checks++; if (tag_out_valid !== 1'b0 || tag_out !== {16{8'hAA}} || tagmask_start !== 1'b0) begin
      n_fail++; $display("FAIL enc_hold: got tov %b tag %h tms %b want 0 AA.. 0", tag_out_valid, tag_out, tagmask_start); end
    tag_pre_xor_valid = 0; tagmask_valid = 0;
  endtask

  task automatic test_decrypt_trunc();
    logic [127:0] pre, msk, km, tin, exp_tag;
    pre = rnd128(); msk = rnd128();
    km  = model_tag({128{1'b1}}, 128'd0, 12);
    exp_tag = model_tag(pre, msk, 12);
    tin = exp_tag | (rnd128() & ~km);
    write_tag_in(tin);
    for (int pass = 0; pass < 2; pass++) begin
      do_start(1'b0, 0, 128, 12);
      n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL dec_accept_p%0d: got %0d want 2", pass, phase); end
      pld_valid = 1; pld_ready = 1; pld_keep = 16'hFFFF; tick(); pld_valid = 0; pld_ready = 0;
      if (pass == 1) begin
        tag_in = tin ^ (128'd1 << 120); tag_in_we = 1;
      end
      lens_done = 1; tick(); lens_done = 0; tag_in_we = 0;
      tag_pre_xor = pre; tagmask = msk; tag_pre_xor_valid = 1; tagmask_valid = 1;
      tick();
      n_checks++; if (auth_done !== 1'b1 || tag_out_valid !== 1'b0 || auth_fail !== (pass == 1)) begin
        n_fail++; $display("FAIL dec_auth_p%0d: got ad %b tov %b af %b want 1 0 %b", pass, auth_done, tag_out_valid, auth_fail, pass == 1); end
      n_checks++; if (tag_out !== exp_tag || phase !== 3'd5) begin
        n_fail++; $display("FAIL dec_tag_p%0d: got %h ph %0d want %h ph 5", pass, tag_out, phase, exp_tag); end
      tick();
      tag_pre_xor_valid = 0; tagmask_valid = 0;
      n_checks++; if (auth_done !== 1'b0 || auth_fail !== (pass == 1)) begin
        n_fail++; $display("FAIL dec_hold_p%0d: got ad %b af %b want 0 %b", pass, auth_done, auth_fail, pass == 1); end
    end
  endtask

  task automatic test_zero_len();
    logic [127:0] pre, msk, exp_tag;
    pre = rnd128(); msk = rnd128();
    exp_tag = model_tag(pre, msk, 2);
    do_start(1'b1, 0, 0, 2);
    n_checks++; if (phase !== 3'd3 || ghash_init !== 1'b1 || auth_fail !== 1'b0) begin
      n_fail++; $display("FAIL zero_accept: got phase %0d gi %b af %b want 3 1 0", phase, ghash_init, auth_fail); end
    lens_done = 1; tick(); lens_done = 0;
    tag_pre_xor = pre; tagmask = msk; tag_pre_xor_valid = 1; tagmask_valid = 1;
    tick();
    tag_pre_xor_valid = 0; tagmask_valid = 0;
    n_checks++; if (tag_out !== exp_tag || tag_out[95:0] !== 96'd0 || tag_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL zero_tag: got %h v%b want %h v1", tag_out, tag_out_valid, exp_tag); end
  endtask

  task automatic test_abort();
    do_start(1'b1, 0, 256, 16);
    pld_valid = 1; pld_ready = 1; pld_keep = 16'hFFFF; tick();
    n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL abort_pre: got %0d want 2", phase); end
    abort = 1; start = 1; tick(); abort = 0; pld_valid = 0; pld_ready = 0;
    n_checks++; if (phase !== 3'd0 || busy !== 1'b0 || tag_out_valid !== 1'b0 || ghash_init !== 1'b0) begin
      n_fail++; $display("FAIL abort_beat: got phase %0d busy %b tov %b gi %b want 0 0 0 0", phase, busy, tag_out_valid, ghash_init); end
    tick();
    n_checks++; if (phase !== 3'd0 || ghash_init !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_level: got phase %0d gi %b want 0 0", phase, ghash_init); end
    start = 0; tick(); start = 1; tick(); start = 0;
    n_checks++; if (phase !== 3'd2 || ghash_init !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart: got phase %0d gi %b want 2 1", phase, ghash_init); end
    abort = 1; tick(); abort = 0;
    // abort wins over a same-cycle tag completion
    do_start(1'b1, 0, 0, 16);
    lens_done = 1; tick(); lens_done = 0;
    tag_pre_xor = rnd128(); tagmask = rnd128(); tag_pre_xor_valid = 1; tagmask_valid = 1; abort = 1;
    tick();
    abort = 0; tag_pre_xor_valid = 0; tagmask_valid = 0;
    n_checks++; if (phase !== 3'd0 || tag_out_valid !== 1'b0 || auth_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_tag: got phase %0d tov %b ad %b want 0 0 0", phase, tag_out_valid, auth_done); end
  endtask

  task automatic test_len_check();
    logic [127:0] pre, msk;
    pre = rnd128(); msk = rnd128();
    do_start(1'b1, 0, 128, 16);
    pld_valid = 1; pld_ready = 1; pld_keep = 16'h00FF; pld_last = 1; tick();
    pld_valid = 0; pld_ready = 0; pld_last = 0;
`ifdef AES_GCM_SEQ_CTRL_LEN_CHECK_EN
    n_checks++; if (phase !== 3'd6 || len_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL lenchk_err: got phase %0d le %b busy %b want 6 1 0", phase, len_err, busy); end
    lens_done = 1; tag_pre_xor = pre; tagmask = msk; tag_pre_xor_valid = 1; tagmask_valid = 1;
    tick();
    lens_done = 0; tag_pre_xor_valid = 0; tagmask_valid = 0;
    n_checks++; if (phase !== 3'd6 || tag_out_valid !== 1'b0 || len_err !== 1'b1) begin
      n_fail++; $display("FAIL lenchk_hold: got phase %0d tov %b le %b want 6 0 1", phase, tag_out_valid, len_err); end
    do_start(1'b1, 0, 128, 16);
    n_checks++; if (phase !== 3'd2 || len_err !== 1'b0 || ghash_init !== 1'b1) begin
      n_fail++; $display("FAIL lenchk_restart: got phase %0d le %b gi %b want 2 0 1", phase, len_err, ghash_init); end
    abort = 1; tick(); abort = 0;
`else
    n_checks++; if (phase !== 3'd3 || len_err !== 1'b0) begin
      n_fail++; $display("FAIL lenchk_last: got phase %0d le %b want 3 0", phase, len_err); end
    lens_done = 1; tick(); lens_done = 0;
    tag_pre_xor = pre; tagmask = msk; tag_pre_xor_valid = 1; tagmask_valid = 1;
    tick();
    tag_pre_xor_valid = 0; tagmask_valid = 0;
    n_checks++; if (tag_out_valid !== 1'b1 || tag_out !== model_tag(pre, msk, 16)) begin
      n_fail++; $display("FAIL lenchk_tag: got %h v%b want %h v1", tag_out, tag_out_valid, model_tag(pre, msk, 16)); end
`endif
  endtask

  task automatic test_reset_mid_tag();
    logic [127:0] v;
    do_start(1'b1, 0, 0, 16);
    tick();
    start = 1; tick(); start = 0;
    n_checks++; if (phase !== 3'd3 || ghash_init !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored: got phase %0d gi %b want 3 0", phase, ghash_init); end
    lens_done = 1; tick(); lens_done = 0;
    n_checks++; if (phase !== 3'd4) begin n_fail++; $display("FAIL rst_pre_tag: got %0d want 4", phase); end
    rst_n = 0; tick(); rst_n = 1;
    n_checks++; if (phase !== 3'd0 || {busy, ghash_init, tagmask_start, tag_out_valid, auth_done, auth_fail, len_err} !== 7'b0 || tag_out !== 128'd0) begin
      n_fail++; $display("FAIL rst_mid_tag: got phase %0d flags %b tag %h want 0 0 0", phase,
        {busy, ghash_init, tagmask_start, tag_out_valid, auth_done, auth_fail, len_err}, tag_out); end
    // the tag_in register must be back to zero: an all-zero tag authenticates
    v = rnd128();
    do_start(1'b0, 0, 0, 16);
    lens_done = 1; tick(); lens_done = 0;
    tag_pre_xor = v; tagmask = v; tag_pre_xor_valid = 1; tagmask_valid = 1;
    tick();
    tag_pre_xor_valid = 0; tagmask_valid = 0;
    n_checks++; if (auth_done !== 1'b1 || auth_fail !== 1'b0) begin
      n_fail++; $display("FAIL rst_tag_in_cleared: got ad %b af %b want 1 0", auth_done, auth_fail); end
  endtask

  // Randomized operations issued back to back, each starting from DONE.
  task automatic test_back_to_back(input int n_ops);
    for (int op = 0; op < n_ops; op++) begin
      logic          enc;
      int            la_b, lp_b, tl, r, k, exp_ph;
      logic [127:0]  pre, msk, km, tin, exp_tag;
      logic [BB-1:0] keep;
      logic          exp_fail;
      enc  = 1'($urandom_range(0, 1));
      la_b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      lp_b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      tl   = int'($urandom_range(0, 31));
      pre  = rnd128(); msk = rnd128();
      exp_tag = model_tag(pre, msk, tl);
      km   = model_tag({128{1'b1}}, 128'd0, tl);
      tin  = exp_tag | (rnd128() & ~km);
      exp_fail = 1'b0;
      if (!enc && $urandom_range(0, 1) == 1) begin
        tin = tin ^ (128'd1 << (127 - int'($urandom_range(0, 8 * model_tl(tl) - 1))));
        exp_fail = 1'b1;
      end
      do_start(enc, 8 * la_b, 8 * lp_b, tl);
      n_checks++; if (phase !== 3'(model_first(la_b, lp_b)) || ghash_init !== 1'b1 || tag_out !== 128'd0 || auth_fail !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_accept: got phase %0d gi %b tag %h af %b want %0d 1 0 0", op, phase, ghash_init, tag_out, auth_fail, model_first(la_b, lp_b)); end
      for (int s = 0; s < 2; s++) begin
        r = (s == 0) ? la_b : lp_b;
        while (r > 0) begin
          if ($urandom_range(0, 2) == 0) begin
            // stalled handshake plus the other stream firing: nothing may count
            if (s == 0) begin aad_valid = 1'($urandom_range(0, 1)); aad_ready = ~aad_valid; pld_valid = 1; pld_ready = 1; pld_keep = '1; end
            else        begin pld_valid = 1'($urandom_range(0, 1)); pld_ready = ~pld_valid; aad_valid = 1; aad_ready = 1; aad_keep = '1; end
            tick();
            aad_valid = 0; aad_ready = 0; pld_valid = 0; pld_ready = 0;
            n_checks++; if (phase !== 3'(s + 1)) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d want %0d", op, phase, s + 1); end
          end
          keep = BB'($urandom());
          k = $countones(keep);
          if (k == 0 || k > r) begin
            k = (r < BB) ? r : BB;
            keep = BB'((33'h1 << k) - 1);
          end
          if (s == 0) begin aad_valid = 1; aad_ready = 1; aad_keep = keep; aad_last = (k == r) ? 1'($urandom_range(0, 1)) : 1'b0; end
          else        begin pld_valid = 1; pld_ready = 1; pld_keep = keep; pld_last = (k == r) ? 1'($urandom_range(0, 1)) : 1'b0; end
          tick();
          aad_valid = 0; aad_ready = 0; aad_last = 0; pld_valid = 0; pld_ready = 0; pld_last = 0;
          r = r - k;
          if (r > 0)                  exp_ph = s + 1;
          else if (s == 0 && lp_b > 0) exp_ph = 2;
          else                         exp_ph = 3;
          n_checks++; if (phase !== 3'(exp_ph)) begin n_fail++; $display("FAIL rnd%0d_beat: got %0d want %0d", op, phase, exp_ph); end
        end
      end
      repeat ($urandom_range(0, 2)) tick();
      lens_done = 1; tick(); lens_done = 0;
      n_checks++; if (phase !== 3'd4 || tagmask_start !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_tag_entry: got phase %0d tms %b want 4 1", op, phase, tagmask_start); end
      write_tag_in(tin);
      tag_pre_xor = pre; tagmask = msk; tag_pre_xor_valid = 1; tagmask_valid = 1;
      tick();
      n_checks++; if (tag_out !== exp_tag || phase !== 3'd5) begin
        n_fail++; $display("FAIL rnd%0d_tag: got %h ph %0d want %h ph 5", op, tag_out, phase, exp_tag); end
      n_checks++; if (tag_out_valid !== enc || auth_done !== !enc || auth_fail !== exp_fail) begin
        n_fail++; $display("FAIL rnd%0d_result: got tov %b ad %b af %b want %b %b %b", op, tag_out_valid, auth_done, auth_fail, enc, !enc, exp_fail); end
      tick();
      n_checks++; if (tag_out_valid !== 1'b0 || auth_done !== 1'b0 || tag_out !== exp_tag || phase !== 3'd5) begin
        n_fail++; $display("FAIL rnd%0d_once: got tov %b ad %b tag %h ph %0d", op, tag_out_valid, auth_done, tag_out, phase); end
      tag_pre_xor_valid = 0; tagmask_valid = 0;
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_basic();
    test_decrypt_trunc();
    test_zero_len();
    test_abort();
    test_len_check();
    test_reset_mid_tag();
    test_back_to_back(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
